// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel image stream writer: FSM encoding and width helpers.
package sobel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSop,
    StRecv,
    StDone
  } state_e;

  localparam int unsigned XSizeDefault = 100;
  localparam int unsigned YSizeDefault = 100;

  // clog2 clamped to one bit so a dimension of 1 still yields a legal vector.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned XBitsDefault   = bits_for(XSizeDefault);
  localparam int unsigned YBitsDefault   = bits_for(YSizeDefault);
  localparam int unsigned AdrBitsDefault = bits_for(XSizeDefault * YSizeDefault);

endpackage

// File: rtl/sobel_img_coord_counter.sv
// X/Y raster counter: Y is the inner index, wrapping into X; clear and inc may coincide.
module Sobel_ImgCoordCounter
  import sobel_pkg::*;
#(
  parameter int unsigned X_SIZE = 100,
  parameter int unsigned Y_SIZE = 100,
  parameter int unsigned X_BITS = bits_for(X_SIZE),
  parameter int unsigned Y_BITS = bits_for(Y_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last
);

  logic [X_BITS-1:0] x_q, x_d, x_base;
  logic [Y_BITS-1:0] y_q, y_d, y_base;

  // clear together with inc means "pixel (0,0) consumed": next position is (0,1).
  always_comb begin
    x_base = clear ? '0 : x_q;
    y_base = clear ? '0 : y_q;
    x_d    = x_base;
    y_d    = y_base;
    if (inc) begin
      if (y_base == Y_BITS'(Y_SIZE - 1)) begin
        y_d = '0;
        x_d = (x_base == X_BITS'(X_SIZE - 1)) ? '0 : x_base + X_BITS'(1);
      end else begin
        y_d = y_base + Y_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_BITS'(X_SIZE - 1)) && (y_q == Y_BITS'(Y_SIZE - 1));

endmodule

// File: rtl/sobel_img_stream_writer.sv
// Avalon-ST sink that writes one frame of pixels into image memory in raster order.
module sobel_img_stream_writer
  import sobel_pkg::*;
#(
  parameter int unsigned X_SIZE   = 100,
  parameter int unsigned Y_SIZE   = 100,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned X_BITS   = bits_for(X_SIZE),
  parameter int unsigned Y_BITS   = bits_for(Y_SIZE),
  parameter int unsigned ADR_BITS = bits_for(X_SIZE * Y_SIZE)
) (
  input  logic                Clk_i,
  input  logic                RstN_i,
  input  logic                Start_i,
  input  logic [DATA_W-1:0]   SinkData_i,
  input  logic                SinkValid_i,
  input  logic                SinkSop_i,
  input  logic                SinkEop_i,
  output logic                SinkReady_o,
  output logic                MemWrEn_o,
  output logic [ADR_BITS-1:0] MemWrAdr_o,
  output logic [DATA_W-1:0]   MemWrData_o,
  output logic [X_BITS-1:0]   X_o,
  output logic [Y_BITS-1:0]   Y_o,
  output logic                Busy_o,
  output logic                Done_o,
  output logic                Err_o
);

  state_e              state_q;
  logic                accept;
  logic                last;
  logic                ctr_clear;
  logic                ctr_inc;
  logic                wr_go;
  logic                at_origin;
  logic [ADR_BITS-1:0] wr_adr;

  assign SinkReady_o = (state_q == StWaitSop) || (state_q == StRecv);
  assign Busy_o      = (state_q != StIdle);
  assign Done_o      = (state_q == StDone);
  assign accept      = SinkValid_i && SinkReady_o;

  Sobel_ImgCoordCounter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_coord (
    .clk   (Clk_i),
    .rst_n (RstN_i),
    .clear (ctr_clear),
    .inc   (ctr_inc),
    .x     (X_o),
    .y     (Y_o),
    .last  (last)
  );

  always_comb begin
    ctr_clear = 1'b0;
    ctr_inc   = 1'b0;
    wr_go     = 1'b0;
    at_origin = 1'b0;
    unique case (state_q)
      StIdle:    ctr_clear = Start_i;
      StWaitSop: begin
        if (accept && SinkSop_i) begin
          wr_go     = 1'b1;
          at_origin = 1'b1;
          ctr_clear = 1'b1;
          ctr_inc   = 1'b1;
        end
      end
      StRecv: begin
        if (accept) begin
          wr_go     = 1'b1;
          ctr_inc   = 1'b1;
          at_origin = SinkSop_i;
          ctr_clear = SinkSop_i;
        end
      end
      default: ;
    endcase
  end

  assign wr_adr = at_origin ? '0
                : ADR_BITS'(X_o) * ADR_BITS'(Y_SIZE) + ADR_BITS'(Y_o);

  always_ff @(posedge Clk_i) begin
    if (!RstN_i) begin
      state_q     <= StIdle;
      MemWrEn_o   <= 1'b0;
      MemWrAdr_o  <= '0;
      MemWrData_o <= '0;
      Err_o       <= 1'b0;
    end else begin
      MemWrEn_o <= wr_go;
      if (wr_go) begin
        MemWrAdr_o  <= wr_adr;
        MemWrData_o <= SinkData_i;
      end
      unique case (state_q)
        StIdle: begin
          if (Start_i) begin
            Err_o   <= 1'b0;
            state_q <= StWaitSop;
          end
        end
        StWaitSop: begin
          if (accept) begin
            if (!SinkSop_i) begin
              Err_o <= 1'b1;
            end else if (SinkEop_i) begin
              Err_o   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRecv;
            end
          end
        end
        StRecv: begin
          if (accept) begin
            if (SinkSop_i) begin
              // Unexpected SOP restarts the frame at the origin.
              Err_o <= 1'b1;
              if (SinkEop_i) state_q <= StDone;
            end else if (last) begin
              state_q <= StDone;
              if (!SinkEop_i) Err_o <= 1'b1;
            end else if (SinkEop_i) begin
              Err_o   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_img_stream_writer.sv
// Directed bench for sobel_img_stream_writer on a 4x3 image with a write scoreboard.
module tb_sobel_img_stream_writer;

  localparam int unsigned XS = 4;
  localparam int unsigned YS = 3;
  localparam int unsigned DW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       valid;
  logic       sop;
  logic       eop;
  logic [7:0] data;
  logic       ready;
  logic       wr_en;
  logic [3:0] wr_adr;
  logic [7:0] wr_data;
  logic [1:0] x;
  logic [1:0] y;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  sobel_img_stream_writer #(
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .DATA_W (DW)
  ) dut (
    .Clk_i       (clk),
    .RstN_i      (rst_n),
    .Start_i     (start),
    .SinkData_i  (data),
    .SinkValid_i (valid),
    .SinkSop_i   (sop),
    .SinkEop_i   (eop),
    .SinkReady_o (ready),
    .MemWrEn_o   (wr_en),
    .MemWrAdr_o  (wr_adr),
    .MemWrData_o (wr_data),
    .X_o         (x),
    .Y_o         (y),
    .Busy_o      (busy),
    .Done_o      (done),
    .Err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Offer one beat and hold it until accepted; optionally expect a write at adr.
  task automatic send(input logic [7:0] d, input logic s, input logic e,
                      input bit expw, input int adr);
    int n;
    n     = 0;
    data  = d;
    sop   = s;
    eop   = e;
    valid = 1'b1;
    if (expw) exp_q.push_back({adr[3:0], d});
    while (ready !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    total++;
    assert (n < 40) else begin
      bad++;
      $error("FAIL beat_timeout observed=%0d cycles expected<40", n);
    end
    tick(1);
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
  endtask

  task automatic frame(input bit gaps, input int first);
    for (int i = first; i < 12; i++) begin
      if (gaps) tick($urandom_range(0, 2));
      if (gaps && i == 3) begin
        check("gap_x_before_beat3", 32'(x), 32'd1);
        check("gap_y_before_beat3", 32'(y), 32'd0);
      end
      send(8'(16 + i), i == 0, i == 11, 1'b1, i);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (wr_en === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_write observed adr=%0d data=%0h expected no write", wr_adr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_adr", 32'(wr_adr), 32'(e[11:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    data  = '0;
    tick(2);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wren", 32'(wr_en), 0);
    check("rst_adr", 32'(wr_adr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_xy", {x, y}, 0);
    rst_n = 1'b1;
    tick(1);

    // Back-to-back frame
    pulse_start();
    check("a_busy", 32'(busy), 1);
    check("a_ready", 32'(ready), 1);
    frame(1'b0, 0);
    check("a_done", 32'(done), 1);
    check("a_err", 32'(err), 0);
    check("a_ready_in_done", 32'(ready), 0);
    tick(1);
    check("a_done_off", 32'(done), 0);
    check("a_busy_off", 32'(busy), 0);

    // Frame with random valid gaps
    pulse_start();
    frame(1'b1, 0);
    check("b_done", 32'(done), 1);
    check("b_err", 32'(err), 0);
    tick(2);

    // Two beats without SOP are dropped, then a clean frame
    pulse_start();
    send(8'hE0, 1'b0, 1'b0, 1'b0, 0);
    send(8'hE1, 1'b0, 1'b0, 1'b0, 0);
    check("c_err_set", 32'(err), 1);
    check("c_still_waiting", 32'(ready), 1);
    frame(1'b0, 0);
    check("c_done", 32'(done), 1);
    check("c_err_sticky", 32'(err), 1);
    tick(2);

    // Early EOP on the 5th beat
    pulse_start();
    check("d_err_cleared", 32'(err), 0);
    for (int i = 0; i < 5; i++) send(8'(16 + i), i == 0, i == 4, 1'b1, i);
    check("d_done", 32'(done), 1);
    check("d_err", 32'(err), 1);
    check("d_ready", 32'(ready), 0);
    tick(3);
    check("d_x_hold", 32'(x), 1);
    check("d_y_hold", 32'(y), 2);

    // Reset mid-frame with a beat on the bus
    pulse_start();
    for (int i = 0; i < 6; i++) send(8'(16 + i), i == 0, 1'b0, 1'b1, i);
    valid = 1'b1;
    data  = 8'h55;
    rst_n = 1'b0;
    tick(1);
    check("e_wren", 32'(wr_en), 0);
    check("e_adr", 32'(wr_adr), 0);
    check("e_data", 32'(wr_data), 0);
    check("e_busy", 32'(busy), 0);
    check("e_err", 32'(err), 0);
    check("e_xy", {x, y}, 0);
    valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("e_idle_ready", 32'(ready), 0);
    check("e_idle_busy", 32'(busy), 0);

    // Start mid-frame is ignored; beats offered in IDLE are never taken
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'(16 + i), i == 0, 1'b0, 1'b1, i);
    pulse_start();
    frame(1'b0, 3);
    check("f_done", 32'(done), 1);
    check("f_err", 32'(err), 0);
    tick(1);
    valid = 1'b1;
    sop   = 1'b1;
    data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      check("f_idle_ready", 32'(ready), 0);
      tick(1);
    end
    valid = 1'b0;
    sop   = 1'b0;
    tick(3);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_img_stream_writer.md
SOBEL_IMG_STREAM_WRITER -- requirements
Module: sobel_img_stream_writer

Interface
REQ-001 Parameter X_SIZE, default 100: image rows, the outer index.
REQ-002 Parameter Y_SIZE, default 100: pixels per row, the inner index.
REQ-003 Parameter DATA_W, default 8: pixel width.
REQ-004 Derived widths SHALL be X_BITS=clog2(X_SIZE), Y_BITS=clog2(Y_SIZE) and ADR_BITS=clog2(X_SIZE*Y_SIZE); X_SIZE*Y_SIZE SHALL be at least 2.
REQ-005 Clk_i  in  1  single clock; all logic rising-edge.
REQ-006 RstN_i  in  1  reset, synchronous, active-low.
REQ-007 Start_i  in  1  arm for one frame.
REQ-008 SinkData_i  in  DATA_W  Avalon-ST pixel.
REQ-009 SinkValid_i / SinkSop_i / SinkEop_i  in  1 each  Avalon-ST valid, startofpacket, endofpacket.
REQ-010 SinkReady_o  out  1  Avalon-ST ready, readyLatency 0.
REQ-011 MemWrEn_o  out  1  image-memory write strobe.
REQ-012 MemWrAdr_o  out  ADR_BITS  write address.
REQ-013 MemWrData_o  out  DATA_W  write data.
REQ-014 X_o  out  X_BITS and Y_o  out  Y_BITS  coordinates of the next expected pixel.
REQ-015 Busy_o  out  1;  Done_o  out  1  one-cycle pulse;  Err_o  out  1  sticky protocol error.

Function
REQ-016 A beat SHALL be accepted when SinkValid_i and SinkReady_o are both high in the same cycle.
REQ-017 The FSM SHALL have the states IDLE, WAIT_SOP, RECV and DONE.
REQ-018 SinkReady_o SHALL be high only in WAIT_SOP and RECV, decoded from the state register only.
REQ-019 Busy_o SHALL be high in every state except IDLE.
REQ-020 In IDLE, Start_i SHALL clear X, Y and Err_o and move the FSM to WAIT_SOP; Start_i in any other state SHALL be ignored.
REQ-021 In WAIT_SOP, an accepted beat without SOP SHALL be dropped (no write) and SHALL set Err_o.
REQ-022 In WAIT_SOP, an accepted beat with SOP SHALL be written at (0,0) and move the FSM to RECV.
REQ-023 Each accepted, non-dropped beat SHALL produce exactly one registered write one cycle later: MemWrEn_o=1, MemWrAdr_o=X*Y_SIZE+Y of that beat, MemWrData_o=the beat's data.
REQ-024 After each write, Y SHALL increment; at Y=Y_SIZE-1, Y SHALL wrap to 0 and X SHALL increment.
REQ-025 In RECV, SOP on an accepted beat SHALL set Err_o and restart the frame: the beat is written at (0,0).
REQ-026 In RECV, the pixel at (X_SIZE-1,Y_SIZE-1) SHALL move the FSM to DONE; if EOP is absent on that beat, Err_o SHALL be set.
REQ-027 In RECV, EOP on any earlier pixel SHALL write that pixel, set Err_o and move the FSM to DONE.
REQ-028 DONE SHALL last one cycle, assert Done_o, then return to IDLE; X_o and Y_o SHALL hold their values until the next Start_i.
REQ-029 Beats SHALL never be accepted in IDLE or DONE.
REQ-030 Simultaneous SOP and EOP in WAIT_SOP SHALL be a one-pixel frame: write at 0, set Err_o, go to DONE.

Reset
REQ-031 When RstN_i is low at a clock edge, the FSM SHALL go to IDLE and X, Y, MemWrEn_o, MemWrAdr_o, MemWrData_o, Done_o, Err_o and Busy_o SHALL all be 0.
REQ-032 Reset mid-frame SHALL abort the frame with no further writes; the write pipelined from the previous cycle SHALL be suppressed.

Structure
REQ-033 The state encoding and the clog2-derived width constants SHALL live in the shared package sobel_pkg.
REQ-034 The X/Y wrap counter SHALL be a sub-module, Sobel_ImgCoordCounter (inc, clear, X/Y out, last flag).
REQ-035 The address SHALL be X*Y_SIZE+Y, consistent with the codebase's coordinate-to-address mapping; an incrementing address register is permitted if it is equivalent.

Verification (X_SIZE=4, Y_SIZE=3)
REQ-036 Start, then 12 back-to-back beats with SOP on data 0x10 and EOP on 0x1B -> 12 writes at addresses 0..11 with data 0x10..0x1B, Done_o pulse, Err_o=0.
REQ-037 Same frame with random SinkValid_i gaps -> identical writes; the 4th beat writes address 3 at X=1, Y=0.
REQ-038 Two beats without SOP, then a valid frame -> first two beats not written, Err_o=1, frame written at 0..11.
REQ-039 EOP on the 5th beat -> writes at 0..4, Done_o pulse, Err_o=1, SinkReady_o=0 the next cycle.
REQ-040 RstN_i low after 6 beats -> no write after the reset edge, all outputs 0, the FSM in IDLE.
REQ-041 Start_i pulsed mid-frame and SinkValid_i held high while in IDLE -> Start_i ignored and no write from the IDLE beats.
